if_pc_gen: RTL and testbench

- Instruction-fetch PC generator; sits directly upstream of the synchronous-read instruction memory.
- Owns the program counter and drives the word address and chip enable into the IM each cycle.
- Produces the PC and valid tag of the instruction the IM presents one cycle later, for the ID stage.
- Handles sequential advance, branch/jump redirect (MIPS delay-slot semantics), exception flush and pipeline stall.

---
 rtl/mips_cpu_pkg.sv | 19 +
 rtl/if_pc_gen.sv | 84 ++++++++
 tb/tb_if_pc_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and the IM.
package mips_cpu_pkg;

    localparam int unsigned IM_DEPTH  = 1024;
    localparam int unsigned IM_AW_DEF = $clog2(IM_DEPTH);

    typedef logic [31:0]          pc_t;
    typedef logic [31:0]          inst_t;
    typedef logic [IM_AW_DEF-1:0] im_addr_t;

    localparam logic [31:0] ZERO      = 32'h0000_0000;
    localparam pc_t         RESET_VEC = 32'h0000_0000;

    // Force a target onto a word boundary; misalignment is silently dropped.
    function automatic pc_t align_pc(input pc_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: owns the PC, drives the synchronous-read IM
// and tags the instruction the IM returns one cycle later for the ID stage.
module if_pc_gen
    import mips_cpu_pkg::*;
#(
    parameter pc_t         RESET_PC = RESET_VEC,
    parameter int unsigned IM_AW    = $clog2(IM_DEPTH)
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    output logic [IM_AW-1:0] imaddr,
    output logic             imce,
    output logic [31:0]      fetch_pc,
    output logic [31:0]      id_pc,
    output logic             id_valid
);

    pc_t  pc_q;
    logic run_q;
    logic pend_valid;
    pc_t  pend_pc;

    // IM interface; a flush must fetch the vector even while ID is stalled.
    always_comb begin
        imce     = run_q & (~stall | flush);
        imaddr   = pc_q[IM_AW+1:2];
        fetch_pc = pc_q;
    end

    // PC, run flag and ID tag update in priority flush > stall > redirect > pending > seq.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_q     <= RESET_PC;
            run_q    <= 1'b0;
            id_pc    <= ZERO;
            id_valid <= 1'b0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else if (flush) begin
            // Kill the in-flight fetch; id_pc is don't-care while invalid.
            pc_q     <= align_pc(flush_pc);
            id_valid <= 1'b0;
        end else if (stall) begin
            // IM output is frozen, so the ID tag must hold with it.
            pc_q     <= pc_q;
        end else begin
            id_pc    <= pc_q;
            id_valid <= 1'b1;
            if (redirect_valid) begin
                // Delay-slot fetch at the old pc_q stays live.
                pc_q <= align_pc(redirect_pc);
            end else if (pend_valid) begin
                pc_q <= align_pc(pend_pc);
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    // Redirect captured during a stall, replayed when the stall drops; latest wins.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pend_valid <= 1'b0;
            pend_pc    <= ZERO;
        end else if (run_q) begin
            if (flush) begin
                pend_valid <= 1'b0;
            end else if (stall) begin
                if (redirect_valid) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= redirect_pc;
                end
            end else begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed self-checking bench for if_pc_gen.
module tb_if_pc_gen;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [AW-1:0] imaddr;
    logic          imce;
    logic [31:0]   fetch_pc;
    logic [31:0]   id_pc;
    logic          id_valid;

    int total = 0;
    int bad   = 0;

    if_pc_gen #(
        .RESET_PC(32'h0000_0000),
        .IM_AW   (AW)
    ) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .imaddr        (imaddr),
        .imce          (imce),
        .fetch_pc      (fetch_pc),
        .id_pc         (id_pc),
        .id_valid      (id_valid)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs and samples sit 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        flush = 1'b0; flush_pc = '0;
        #12;
        total++; if (imce !== 1'b0) begin bad++; $display("FAIL rst_imce got=%b exp=0", imce); end
        total++; if (imaddr !== 10'h0) begin bad++; $display("FAIL rst_imaddr got=%h exp=0", imaddr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL rst_fetch_pc got=%h exp=0", fetch_pc); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (imce !== 1'b1) begin bad++; $display("FAIL c1_imce got=%b exp=1", imce); end
        total++; if (imaddr !== 10'h0) begin bad++; $display("FAIL c1_imaddr got=%h exp=0", imaddr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL c1_id_valid got=%b exp=0", id_valid); end
        tick();
        total++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin bad++; $display("FAIL c2_id got=%h/%b exp=0/1", id_pc, id_valid); end
        total++; if (fetch_pc !== 32'h4) begin bad++; $display("FAIL c2_fetch got=%h exp=4", fetch_pc); end
        tick();
        total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL c3_id_pc got=%h exp=4", id_pc); end
        total++; if (fetch_pc !== 32'h8) begin bad++; $display("FAIL c3_fetch got=%h exp=8", fetch_pc); end
    endtask

    task automatic test_stall();
        tick(); tick();
        total++; if (fetch_pc !== 32'h10) begin bad++; $display("FAIL st_pre_fetch got=%h exp=10", fetch_pc); end
        stall = 1'b1;
        #1;
        total++; if (imce !== 1'b0) begin bad++; $display("FAIL st_imce got=%b exp=0", imce); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (fetch_pc !== 32'h10 || id_pc !== 32'hC || id_valid !== 1'b1 || imce !== 1'b0) begin
                bad++;
                $display("FAIL st_hold%0d got=%h/%h/%b/%b exp=10/c/1/0", i, fetch_pc, id_pc, id_valid, imce);
            end
        end
        stall = 1'b0;
        tick();
        total++; if (id_pc !== 32'h10 || fetch_pc !== 32'h14) begin bad++; $display("FAIL st_rel got=%h/%h exp=10/14", id_pc, fetch_pc); end
    endtask

    task automatic test_redirect();
        tick(); tick(); tick(); tick();
        total++; if (fetch_pc !== 32'h24) begin bad++; $display("FAIL rd_pre got=%h exp=24", fetch_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        total++; if (id_pc !== 32'h24 || id_valid !== 1'b1 || fetch_pc !== 32'h200) begin
            bad++; $display("FAIL rd_slot got=%h/%b/%h exp=24/1/200", id_pc, id_valid, fetch_pc);
        end
        tick();
        total++; if (id_pc !== 32'h200 || fetch_pc !== 32'h204) begin bad++; $display("FAIL rd_tgt got=%h/%h exp=200/204", id_pc, fetch_pc); end
    endtask

    task automatic test_pending();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h340;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (fetch_pc !== 32'h204) begin bad++; $display("FAIL pd_hold got=%h exp=204", fetch_pc); end
        stall = 1'b0;
        tick();
        total++; if (fetch_pc !== 32'h340 || id_pc !== 32'h204 || id_valid !== 1'b1) begin
            bad++; $display("FAIL pd_apply got=%h/%h/%b exp=340/204/1", fetch_pc, id_pc, id_valid);
        end
        tick();
        total++; if (id_pc !== 32'h340 || fetch_pc !== 32'h344) begin bad++; $display("FAIL pd_next got=%h/%h exp=340/344", id_pc, fetch_pc); end
    endtask

    task automatic test_flush();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        flush = 1'b1; flush_pc = 32'h183;
        #1;
        total++; if (imce !== 1'b1) begin bad++; $display("FAIL fl_imce got=%b exp=1", imce); end
        tick();
        stall = 1'b0; redirect_valid = 1'b0; flush = 1'b0;
        total++; if (id_valid !== 1'b0 || fetch_pc !== 32'h180) begin bad++; $display("FAIL fl_kill got=%b/%h exp=0/180", id_valid, fetch_pc); end
        tick();
        total++; if (id_pc !== 32'h180 || id_valid !== 1'b1 || fetch_pc !== 32'h184) begin
            bad++; $display("FAIL fl_vec got=%h/%b/%h exp=180/1/184", id_pc, id_valid, fetch_pc);
        end
    endtask

    task automatic test_wrap_alias();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (fetch_pc !== 32'hFFFF_FFFC || imaddr !== 10'h3FF) begin bad++; $display("FAIL wr_top got=%h/%h exp=fffffffc/3ff", fetch_pc, imaddr); end
        tick();
        total++; if (fetch_pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_wrap got=%h/%h exp=0/fffffffc", fetch_pc, id_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h8003;
        tick();
        redirect_valid = 1'b0;
        total++; if (fetch_pc !== 32'h8000 || imaddr !== 10'h000) begin bad++; $display("FAIL wr_alias got=%h/%h exp=8000/0", fetch_pc, imaddr); end
        tick();
        total++; if (imaddr !== 10'h001) begin bad++; $display("FAIL wr_alias2 got=%h exp=1", imaddr); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || imce !== 1'b0 || fetch_pc !== 32'h0) begin
            bad++; $display("FAIL mr_async got=%b/%b/%h exp=0/0/0", id_valid, imce, fetch_pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || fetch_pc !== 32'h4) begin
            bad++; $display("FAIL mr_restart got=%h/%b/%h exp=0/1/4", id_pc, id_valid, fetch_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_pending();
        test_flush();
        test_wrap_alias();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
